// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, accumulator sizing and FSM encoding for the conv layer
package cnn_pkg;
  localparam int B = 8;
  localparam int WB = 8;
  localparam int SHIFT = 7;
  typedef enum logic {LOAD, RUN} state_t;
  function automatic int acc_w(input int b, input int wb, input int taps);
    return b + wb + $clog2(taps) + 1;
  endfunction
endpackage

// File: rtl/conv3x3_mac_if.sv
// conv3x3_mac_if: weight load, window input and feature output signals of one conv channel
interface conv3x3_mac_if import cnn_pkg::*; #(parameter int kx = 3, parameter int ky = 3);
  localparam int ACC = acc_w(B, WB, kx*ky);
  logic i_wt_start;
  logic [WB-1:0] i_wt_data;
  logic i_wt_valid;
  logic [ACC-1:0] i_bias;
  logic o_wt_ready;
  logic [kx*ky*B-1:0] i_pixel_data;
  logic i_pixel_data_valid;
  logic [B-1:0] o_conv_data;
  logic o_conv_data_valid;
  logic o_line_done;
  logic o_frame_done;
  logic o_err;
  modport master(
    output i_wt_start, i_wt_data, i_wt_valid, i_bias, i_pixel_data, i_pixel_data_valid,
    input o_wt_ready, o_conv_data, o_conv_data_valid, o_line_done, o_frame_done, o_err
  );
  modport slave(
    input i_wt_start, i_wt_data, i_wt_valid, i_bias, i_pixel_data, i_pixel_data_valid,
    output o_wt_ready, o_conv_data, o_conv_data_valid, o_line_done, o_frame_done, o_err
  );
endinterface

// File: rtl/conv_mult_row.sv
// conv_mult_row: one kernel row of unsigned-pixel x signed-weight multipliers, products registered
module conv_mult_row import cnn_pkg::*; #(parameter int kx = 3) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic [kx*B-1:0] i_pix,
  input  logic [kx*WB-1:0] i_wt,
  output logic [kx*(B+WB+1)-1:0] o_prod
);
  localparam int PW = B + WB + 1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_prod <= '0;
    else
      for (int c = 0; c < kx; c++)
        o_prod[c*PW +: PW] <= PW'($signed({1'b0, i_pix[c*B +: B]})) * PW'($signed(i_wt[c*WB +: WB]));
endmodule

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: 3x3 signed kernel + bias, ReLU, requantise and saturate; 3-cycle pipeline
module conv3x3_mac import cnn_pkg::*; #(
  parameter int kx = 3,
  parameter int ky = 3,
  parameter int F = 28
) (
  input logic i_clk,
  input logic i_rst_n,
  conv3x3_mac_if.slave bus
);
  localparam int N = kx*ky;
  localparam int ACC = acc_w(B, WB, N);
  localparam int PW = B + WB + 1;
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(F);
  localparam logic [CW-1:0] LC = CW'(F - kx);
  localparam logic [CW-1:0] LR = CW'(F - ky);
  state_t state;
  logic [IW-1:0] idx;
  logic [N*WB-1:0] wts;
  logic [N*PW-1:0] prod;
  logic signed [ACC-1:0] bias, p0, p1, s2a, s2b, s, sh;
  logic [B-1:0] r;
  logic [CW-1:0] col, row;
  logic pend, v1, v2, accept, empty;
  genvar i;
  for (i = 0; i < ky; i++) begin : g_row
    conv_mult_row #(.kx(kx)) u_row (
      .i_clk(i_clk),
      .i_rst_n(i_rst_n),
      .i_pix(bus.i_pixel_data[i*kx*B +: kx*B]),
      .i_wt(wts[i*kx*WB +: kx*WB]),
      .o_prod(prod[i*kx*PW +: kx*PW])
    );
  end
  assign accept = state == RUN && bus.i_pixel_data_valid;
  assign empty = !v1 && !v2 && !bus.o_conv_data_valid && !bus.i_pixel_data_valid;
  assign bus.o_wt_ready = state == LOAD;
  always_comb begin
    s2a = '0;
    s2b = '0;
    for (int t = 0; t < N; t++)
      if (t < (N + 1) / 2) s2a = s2a + ACC'($signed(prod[t*PW +: PW]));
      else s2b = s2b + ACC'($signed(prod[t*PW +: PW]));
    s = p0 + p1 + bias;
    sh = s >>> SHIFT;
    r = s[ACC-1] ? '0 : (|sh[ACC-1:B]) ? '1 : sh[B-1:0];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= LOAD;
      idx <= '0;
      wts <= '0;
      bias <= '0;
      pend <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      p0 <= '0;
      p1 <= '0;
      col <= '0;
      row <= '0;
      bus.o_conv_data <= '0;
      bus.o_conv_data_valid <= 1'b0;
      bus.o_line_done <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_err <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      p0 <= s2a;
      p1 <= s2b;
      bus.o_conv_data_valid <= v2;
      bus.o_line_done <= v2 && col == LC;
      bus.o_frame_done <= v2 && col == LC && row == LR;
      if (v2) begin
        bus.o_conv_data <= r;
        col <= col == LC ? '0 : col + 1'b1;
        row <= col != LC ? row : (row == LR ? '0 : row + 1'b1);
      end
      if (state == LOAD && bus.i_pixel_data_valid) bus.o_err <= 1'b1;
      if (state == LOAD) begin
        if (bus.i_wt_start) idx <= '0;
        else if (bus.i_wt_valid) begin
          wts[idx*WB +: WB] <= bus.i_wt_data;
          idx <= idx == IW'(N - 1) ? '0 : idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            bias <= $signed(bus.i_bias);
            state <= RUN;
          end
        end
      end else begin
        if (bus.i_wt_start) pend <= 1'b1;
        // reload waits until every in-flight window has left the pipeline
        if (pend && empty) begin
          state <= LOAD;
          pend <= 1'b0;
          col <= '0;
          row <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_mac.sv
// tb_conv3x3_mac: directed checks of load, arithmetic, latency, frame counters, reload and reset
module tb_conv3x3_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  conv3x3_mac_if bus ();
  conv3x3_mac dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] win(input int o, input int c);
    logic [71:0] d;
    for (int t = 0; t < 9; t++) d[t*8 +: 8] = 8'(t == 4 ? c : o);
    return d;
  endfunction

  task automatic load(input int o, input int c, input int b);
    for (int t = 0; t < 9; t++) begin
      bus.i_wt_valid = 1'b1;
      bus.i_wt_data = 8'(t == 4 ? c : o);
      bus.i_bias = 21'(b);
      step();
    end
    bus.i_wt_valid = 1'b0;
    chk("ready_low_after_load", 32'(bus.o_wt_ready), 0);
  endtask

  task automatic reload();
    bus.i_wt_start = 1'b1;
    step();
    bus.i_wt_start = 1'b0;
    step();
    chk("ready_after_reload", 32'(bus.o_wt_ready), 1);
  endtask

  task automatic run1(input string tag, input logic [71:0] d, input int exp);
    bus.i_pixel_data = d;
    bus.i_pixel_data_valid = 1'b1;
    step();
    bus.i_pixel_data_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.o_conv_data_valid), 0);
    step();
    chk({tag, "_lat2"}, 32'(bus.o_conv_data_valid), 0);
    step();
    chk({tag, "_valid"}, 32'(bus.o_conv_data_valid), 1);
    chk({tag, "_data"}, 32'(bus.o_conv_data), 32'(exp));
    step();
    chk({tag, "_single"}, 32'(bus.o_conv_data_valid), 0);
    chk({tag, "_hold"}, 32'(bus.o_conv_data), 32'(exp));
  endtask

  initial begin
    int nout, ln, fr, frpos, badpos, baddata, early, rdy_at, seen;
    bus.i_wt_start = 1'b0;
    bus.i_wt_data = '0;
    bus.i_wt_valid = 1'b0;
    bus.i_bias = '0;
    bus.i_pixel_data = '0;
    bus.i_pixel_data_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.o_wt_ready), 1);
    chk("rst_valid", 32'(bus.o_conv_data_valid), 0);
    chk("rst_data", 32'(bus.o_conv_data), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    chk("rst_line", 32'(bus.o_line_done), 0);
    chk("rst_frame", 32'(bus.o_frame_done), 0);
    step();
    rst_n = 1'b1;
    step();

    load(0, 0, 0);
    run1("zero_w", win(255, 255), 0);
    reload();
    load(0, 127, 0);
    run1("centre", win(0, 200), 198);
    reload();
    load(127, 127, 0);
    run1("saturate", win(255, 255), 255);
    reload();
    load(-128, -128, 1000);
    run1("relu", win(10, 10), 0);
    reload();
    load(0, 0, 1000);
    run1("bias_only", win(10, 10), 7);

    // full frame with a reload request part way through; weight words in RUN must be ignored
    reload();
    load(0, 0, 1000);
    nout = 0; ln = 0; fr = 0; frpos = 0; badpos = 0; baddata = 0; early = 0; rdy_at = -1;
    bus.i_pixel_data = win(0, 200);
    bus.i_pixel_data_valid = 1'b1;
    for (int k = 0; k < 690; k++) begin
      if (k == 676) bus.i_pixel_data_valid = 1'b0;
      bus.i_wt_start = (k == 300);
      bus.i_wt_valid = (k < 676);
      bus.i_wt_data = 8'h7f;
      step();
      if (bus.o_conv_data_valid) begin
        nout++;
        if (bus.o_conv_data !== 8'd7) baddata++;
        if (bus.o_line_done !== (nout % 26 == 0)) badpos++;
        if (bus.o_frame_done !== (nout == 676)) badpos++;
        if (bus.o_line_done) ln++;
        if (bus.o_frame_done) begin
          fr++;
          frpos = nout;
        end
      end else if (bus.o_line_done || bus.o_frame_done) badpos++;
      if (bus.o_err) baddata++;
      if (nout < 676 && bus.o_wt_ready) early++;
      if (bus.o_wt_ready && rdy_at < 0) rdy_at = k;
    end
    bus.i_wt_valid = 1'b0;
    bus.i_wt_start = 1'b0;
    chk("frame_outputs", 32'(nout), 676);
    chk("frame_data_err", 32'(baddata), 0);
    chk("line_count", 32'(ln), 26);
    chk("frame_count", 32'(fr), 1);
    chk("frame_pos", 32'(frpos), 676);
    chk("pulse_pos", 32'(badpos), 0);
    chk("ready_early", 32'(early), 0);
    chk("ready_rise_cycle", 32'(rdy_at), 679);
    chk("ready_after_drain", 32'(bus.o_wt_ready), 1);

    // window while loading is dropped and flags a sticky error
    seen = 0;
    bus.i_pixel_data = win(50, 50);
    bus.i_pixel_data_valid = 1'b1;
    step();
    bus.i_pixel_data_valid = 1'b0;
    chk("err_set", 32'(bus.o_err), 1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.o_conv_data_valid) seen++;
    end
    chk("load_drop", 32'(seen), 0);
    chk("err_held", 32'(bus.o_err), 1);

    // asynchronous reset while an output is valid and another window is in flight
    load(0, 0, 1000);
    bus.i_pixel_data = win(1, 1);
    bus.i_pixel_data_valid = 1'b1;
    step();
    step();
    step();
    bus.i_pixel_data_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.o_conv_data_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.o_conv_data_valid), 0);
    chk("async_data", 32'(bus.o_conv_data), 0);
    chk("async_err", 32'(bus.o_err), 0);
    chk("async_ready", 32'(bus.o_wt_ready), 1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.o_conv_data_valid) seen++;
    end
    chk("flushed", 32'(seen), 0);
    chk("post_rst_ready", 32'(bus.o_wt_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv3x3_mac.md
Name: conv3x3_mac

Overview:
- Consumes the 3x3 pixel window stream from the line-buffer controller.
- Applies one signed 3x3 kernel plus bias, then ReLU, requantisation shift and saturation.
- Emits one B-bit feature pixel per input window.
- First compute stage of the conv layer; one instance per output channel.
- Weights are loaded through a serial load interface before each frame.

Parameters:
- B, 8, pixel/feature bit width (pixels unsigned).
- WB, 8, weight bit width (signed two's complement).
- kx, 3, kernel width.
- ky, 3, kernel height.
- F, 28, input feature-map width and height.
- SHIFT, 7, requantisation right shift.
- ACC (localparam), B+WB+$clog2(kx*ky)+1, accumulator width (signed).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_wt_start  in  1  pulse: request (re)load of kernel.
- i_wt_data  in  WB  weight word, tap order 0..kx*ky-1.
- i_wt_valid  in  1  weight word valid.
- i_bias  in  ACC  signed bias, sampled with the last weight word.
- o_wt_ready  out  1  high while in LOAD and accepting weights.
- i_pixel_data  in  kx*ky*B  window; tap t = bits [t*B +: B], t = row*kx + col, row 0 oldest line.
- i_pixel_data_valid  in  1  window valid.
- o_conv_data  out  B  output feature pixel.
- o_conv_data_valid  out  1  output valid.
- o_line_done  out  1  one-cycle pulse with the last output of a row.
- o_frame_done  out  1  one-cycle pulse with the last output of a frame.
- o_err  out  1  sticky: window received while not in RUN.

Behaviour:
- Reset (async, i_rst_n low): state = LOAD, tap index 0, all weights and bias 0, pipeline valids 0, counters 0. All outputs 0 except o_wt_ready = 1.
- State LOAD:
  - o_wt_ready = 1; each i_wt_valid stores i_wt_data into weight[idx] and increments idx.
  - At idx = kx*ky-1 with i_wt_valid: also latch i_bias, clear idx, go to RUN next cycle.
  - i_pixel_data_valid in LOAD: window dropped, o_err set; o_err is cleared only by reset.
  - i_wt_start in LOAD restarts loading at idx 0.
- State RUN:
  - o_wt_ready = 0; i_wt_valid is ignored.
  - i_wt_start sets a pending flag. When the pipeline is empty (no valid in any stage and no input valid that cycle), go to LOAD, clear the pending flag, and clear the column and row counters.
  - A window arriving while the flag is pending is still processed.
- Pipeline: fixed 3-cycle latency, no back-pressure, one window per cycle sustained.
  - S1: each tap zero-extended to B+1 signed bits, multiplied by the signed weight; 9 products registered, each B+WB+1 bits.
  - S2: two partial sums (taps 0-4, taps 5-8) registered, sign-extended to ACC.
  - S3: s = p0 + p1 + bias. If s < 0, r = 0; else r = s >>> SHIFT (truncate). If r > 2^B-1, r = 2^B-1. Register o_conv_data = r.
  - o_conv_data_valid = S3 valid. o_conv_data holds its last value when not valid.
- Counters (advance on output valid):
  - col counts 0..F-kx; at F-kx it wraps to 0, o_line_done pulses and row increments.
  - row counts 0..F-ky; on the last col of the last row, o_frame_done pulses together with o_line_done, and both counters clear.
  - Outputs per frame = (F-kx+1)*(F-ky+1) = 676 at defaults.
- Weights are stable throughout RUN, so no in-flight window ever sees new weights.

Decomposition:
- Shared package cnn_pkg holds B, WB, SHIFT, the ACC width function, and the LOAD/RUN state encoding.
- One natural sub-module, conv_mult_row: one kernel row (kx taps), its multipliers and the S1 registers. Instantiated ky times.

Test Plan:
- Load weights all 0, bias 0; window all 255 -> output 0, valid exactly 3 cycles after input valid.
- Load centre weight 127, others 0, bias 0; centre tap 200 -> 200*127 >> 7 = 198.
- All weights 127, bias 0; all taps 255 -> 291465 >> 7 = 2277, saturates to 255.
- All weights -128, bias 1000; all taps 10 -> sum -10520, ReLU gives 0. Then weights 0, bias 1000 -> 1000 >> 7 = 7.
- Stream 676 back-to-back windows -> 26 o_line_done pulses, 1 o_frame_done on output 676, counters back at 0. Pulse i_wt_start mid-stream -> LOAD entered only after the last output drains, and o_wt_ready rises then.
- Window while in LOAD -> no output, o_err = 1 and held. Assert i_rst_n low mid-pipeline -> valids clear immediately, state LOAD, o_err cleared.
